// File: rtl/uart_pkg.sv
// uart_pkg: FSM state type and sizing helpers shared by the UART transmitter files
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_e;
    function automatic int calc_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction
    function automatic int cnt_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO with wrap-bit pointers and a registered occupancy count
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wptr, rptr;
    logic do_push, do_pop;
    assign empty = wptr == rptr;
    assign full = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign rdata = mem[rptr[AW-1:0]];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            level <= '0;
        end else begin
            wptr <= wptr + (AW+1)'(do_push);
            rptr <= rptr + (AW+1)'(do_pop);
            level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param: FIFO-buffered UART transmitter; define UART_TX_PARITY_EN to add a parity bit
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    input  logic                          parity_odd,
    output logic                          uart_tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int DIV = calc_div(CLK_FREQ, BAUD);
    localparam int CW = cnt_w(DIV);
    localparam int IW = cnt_w(DATA_BITS);
    uart_state_e state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [IW-1:0] idx, idx_n;
    logic [DATA_BITS-1:0] sh, sh_n, fifo_rdata;
    logic tx_n, tick, stop_done, load, full, empty;
`ifdef UART_TX_PARITY_EN
    logic par, par_n;
`else
    logic unused_parity;
    assign unused_parity = parity_odd;
`endif
    assign tick = state != IDLE && cnt == CW'(DIV-1);
    assign stop_done = state == STOP && tick && idx == IW'(STOP_BITS-1);
    // a new frame starts from IDLE or straight out of the last stop tick, so no idle gap
    assign load = !empty && (state == IDLE || stop_done);
    assign busy = state != IDLE;
    assign tx_ready = !full;

    uart_tx_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(tx_valid),
        .pop(load),
        .wdata(tx_data),
        .rdata(fifo_rdata),
        .full(full),
        .empty(empty),
        .level(fifo_level)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            idx <= '0;
            sh <= '0;
            uart_tx <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par <= 1'b0;
`endif
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            idx <= idx_n;
            sh <= sh_n;
            uart_tx <= tx_n;
`ifdef UART_TX_PARITY_EN
            par <= par_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        cnt_n = (state == IDLE || tick) ? '0 : cnt + CW'(1);
        idx_n = idx;
        sh_n = sh;
        tx_n = uart_tx;
`ifdef UART_TX_PARITY_EN
        par_n = par;
`endif
        case (state)
            START: if (tick) begin
                state_n = DATA;
                idx_n = '0;
                tx_n = sh[0];
                sh_n = sh >> 1;
            end
            DATA: if (tick) begin
                if (idx == IW'(DATA_BITS-1)) begin
`ifdef UART_TX_PARITY_EN
                    state_n = PARITY;
                    tx_n = par;
`else
                    state_n = STOP;
                    tx_n = 1'b1;
                    idx_n = '0;
`endif
                end else begin
                    idx_n = idx + IW'(1);
                    tx_n = sh[0];
                    sh_n = sh >> 1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (tick) begin
                state_n = STOP;
                tx_n = 1'b1;
                idx_n = '0;
            end
`endif
            STOP: if (tick) begin
                idx_n = idx + IW'(1);
                if (stop_done) begin
                    state_n = IDLE;
                    tx_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        if (load) begin
            state_n = START;
            sh_n = fifo_rdata;
            tx_n = 1'b0;
`ifdef UART_TX_PARITY_EN
            par_n = ^fifo_rdata ^ parity_odd;
`endif
        end
    end
endmodule
